serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, giving the operand and result width in bits, with legal range 1..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled only while ready=1.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend, unsigned.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend, unsigned.
REQ-007 The block SHALL have port bin, input, 1 bit: borrow-in, applied at bit 0.
REQ-008 The block SHALL have port ready, output, 1 bit: high when the block can accept start.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse marking dif/brw valid.
REQ-010 The block SHALL have port dif, output, WIDTH bits: difference a - b - bin, mod 2^WIDTH.
REQ-011 The block SHALL have port brw, output, 1 bit: final borrow-out, 1 iff a < b + bin.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, RUN and DONE, encoded as a registered state.
REQ-013 In IDLE: ready=1, done=0; if start=1 at a rising edge, the block SHALL capture a, b and bin into internal shift/borrow registers, clear the bit counter to 0 and go to RUN.
REQ-014 In IDLE with start=0, the block SHALL stay in IDLE with all registers unchanged.
REQ-015 In RUN: ready=0, done=0; each edge SHALL process exactly one bit, LSB first, using full-subtractor logic.
REQ-016 The per-bit logic SHALL be d = ai ^ bi ^ br and br_next = (~ai & bi) | (~(ai ^ bi) & br).
REQ-017 In RUN, d SHALL shift into the result register from the MSB end, the operand registers SHALL shift right by one, br SHALL update to br_next, and the counter SHALL increment.
REQ-018 When the counter equals WIDTH-1 in RUN, the block SHALL process the last bit, load brw with br_next, and go to DONE on that edge; the counter SHALL never exceed WIDTH-1.
REQ-019 In DONE, the block SHALL drive done=1 and ready=0 for exactly one cycle, then go to IDLE unconditionally.
REQ-020 Latency SHALL be fixed: if start is accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH.
REQ-021 Throughput SHALL be one operation per WIDTH+2 cycles; back-to-back start held high SHALL be accepted on the first IDLE edge after DONE.
REQ-022 Start asserted in RUN or DONE SHALL be ignored, with no queuing and no effect on the in-flight result.
REQ-023 Changes on a, b or bin after the accepting edge SHALL NOT affect the result.
REQ-024 dif and brw SHALL hold their last completed values from DONE through IDLE until the next accepted operation reaches DONE.
REQ-025 dif and brw SHALL be driven directly from registers, with no combinational path from inputs to outputs.
REQ-026 For WIDTH=1, RUN SHALL last exactly one cycle.

Reset
REQ-027 When rst_n=0, the block SHALL immediately, without waiting for a clock edge, force state=IDLE, ready=1, done=0, dif=0, brw=0, counter=0 and the internal operand and borrow registers to 0.
REQ-028 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse.
REQ-029 The first start SHALL be accepted on the first rising edge after rst_n returns high.

Verification
REQ-030 WIDTH=8; a=0x5A, b=0x3C, bin=0, start pulse -> done 8 cycles after the accept edge; dif=0x1E, brw=0.
REQ-031 a=0x00, b=0x01, bin=0 -> dif=0xFF, brw=1; then a=0x80, b=0x80, bin=1 -> dif=0xFF, brw=1.
REQ-032 Start accepted with a=0x10, b=0x01; at RUN cycle 3 drive start=1 with a=0xFF, b=0x00 -> only one done, with dif=0x0F and brw=0; the second request is not accepted.
REQ-033 rst_n pulled low at RUN cycle 4 -> ready=1, dif=0x00, brw=0 immediately, and no done; a new op with a=0x03, b=0x05 -> dif=0xFE, brw=1.
REQ-034 start held high continuously with a=0x09, b=0x04 -> done every 10 cycles, dif=0x05 each time; all 65536 a/b pairs with random bin are checked against a reference model.
REQ-035 WIDTH=1; all 8 combinations of a, b, bin -> dif and brw match the full-subtractor truth table, with done 1 cycle after accept.

Source files
------------

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial unsigned subtractor computing a - b - bin,
//                one bit per clock, LSB first, with IDLE/RUN/DONE control.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] dif,
  output logic             brw
);

  // A one-bit operand still needs a one-bit counter, hence the floor of 1.
  localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_br;
  logic [WIDTH-1:0]   r_res;
  logic [WIDTH-1:0]   r_dif;
  logic               r_brw;

  logic               w_ai;
  logic               w_bi;
  logic               w_d;
  logic               w_br_nxt;
  logic [WIDTH-1:0]   w_res_nxt;
  logic               w_last;

  // State register: only control state lives here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: RUN lasts exactly WIDTH cycles, DONE exactly one.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (start)  w_state_nxt = c_st_run;
      c_st_run:  if (w_last) w_state_nxt = c_st_done;
      c_st_done: w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  // Output decode from the registered state only, so no input reaches an output.
  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    case (r_state)
      c_st_idle: ready = 1'b1;
      c_st_done: done  = 1'b1;
      default: begin
        ready = 1'b0;
        done  = 1'b0;
      end
    endcase
  end

  // Full-subtractor slice on the current LSBs and the new result word.
  always_comb begin
    w_ai      = r_a[0];
    w_bi      = r_b[0];
    w_d       = w_ai ^ w_bi ^ r_br;
    w_br_nxt  = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
    w_last    = (r_cnt == c_last);
    // Difference bit enters at the MSB so that after WIDTH shifts bit 0 is at bit 0.
    w_res_nxt = r_res >> 1;
    w_res_nxt[WIDTH-1] = w_d;
  end

  // Datapath: capture on accept, shift while running, publish on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_br  <= 1'b0;
      r_res <= '0;
      r_dif <= '0;
      r_brw <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= bin;
            r_cnt <= '0;
          end
        end
        c_st_run: begin
          r_res <= w_res_nxt;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br_nxt;
          if (w_last) begin
            // Outputs change only here, so they hold through DONE and IDLE.
            r_dif <= w_res_nxt;
            r_brw <= w_br_nxt;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign dif = r_dif;
  assign brw = r_brw;

endmodule
`default_nettype wire
